// File: rtl/seq_detect_arbiter.sv
// seq_detect_arbiter: round-robin sharing of one serial pattern detector among N bit lanes.
// Each grant starts from a cleared window and samples at most BURST bits from its lane.
module seq_detect_arbiter #(
  parameter int              N       = 4,
  parameter int              PLEN    = 3,
  parameter logic [PLEN-1:0] PATTERN = 3'b110,
  parameter int              BURST   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         in,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic                 match,
  output logic [$clog2(N)-1:0] match_id,
  output logic                 done
);
  localparam int         IW      = $clog2(N);
  localparam logic [7:0] BURST_C = 8'(BURST);
  localparam logic [7:0] PLEN_C  = 8'(PLEN);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state, state_n;
  logic [N-1:0]    gnt_n;
  logic [IW-1:0]   last, last_n, match_id_n, winner;
  logic [PLEN-1:0] window, window_n;
  logic [7:0]      count, count_n;
  logic            match_n, done_n;

  // First requester found searching upward from the one after the previous winner.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] l);
    logic [IW-1:0] pick;
    logic          found;
    int            c;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(l) + k) % N;
      if (!found && r[c]) begin
        found = 1'b1;
        pick  = IW'(c);
      end
    end
    return pick;
  endfunction

  assign winner = rr_pick(req, last);

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    last_n     = last;
    window_n   = window;
    count_n    = count;
    match_n    = 1'b0;
    match_id_n = match_id;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (req != '0) begin
          gnt_n         = '0;
          gnt_n[winner] = 1'b1;
          last_n        = winner;
          window_n      = '0;
          count_n       = '0;
          state_n       = GRANT;
        end
      end
      GRANT: begin
        // The owning lane is always 'last'; other lanes are ignored until the grant ends.
        if (req[last]) begin
          window_n   = {window[PLEN-2:0], in[last]};
          count_n    = count + 8'd1;
          match_n    = (count_n >= PLEN_C) && (window_n == PATTERN);
          match_id_n = last;
          if (count_n == BURST_C) begin
            state_n = GAP;
            gnt_n   = '0;
            done_n  = 1'b1;
          end
        end else begin
          state_n = GAP;
          gnt_n   = '0;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      last     <= IW'(N - 1);
      window   <= '0;
      count    <= '0;
      match    <= 1'b0;
      match_id <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      last     <= last_n;
      window   <= window_n;
      count    <= count_n;
      match    <= match_n;
      match_id <= match_id_n;
      done     <= done_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// tb_seq_detect_arbiter: directed and random stimulus checked cycle by cycle against
// a queue-based model of grants, bursts and pattern matches.
module tb_seq_detect_arbiter;
  localparam int           N       = 4;
  localparam int           PLEN    = 3;
  localparam logic [2:0]   PATTERN = 3'b110;
  localparam int           BURST   = 8;
  localparam int           IW      = $clog2(N);

  logic          clk, rst;
  logic [N-1:0]  req, in;
  logic [N-1:0]  gnt;
  logic          busy, match, done;
  logic [IW-1:0] match_id;

  int total, bad;

  // model state: current owner (-1 = none), bits sampled this grant, gap cycles pending
  int     owner, cooldown, m_last, exp_mid;
  bit     q[$];
  logic [N-1:0] exp_gnt;
  logic   exp_busy, exp_match, exp_done;

  int     matchSeen;
  int     grantLog[$];
  logic [N-1:0] prevGnt;

  seq_detect_arbiter #(.N(N), .PLEN(PLEN), .PATTERN(PATTERN), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .in(in), .gnt(gnt), .busy(busy),
    .match(match), .match_id(match_id), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic modelReset();
    owner = -1; cooldown = 0; m_last = N - 1; exp_mid = 0;
    q.delete();
    exp_gnt = '0; exp_busy = 1'b0; exp_match = 1'b0; exp_done = 1'b0;
  endtask

  task automatic modelStep();
    int v;
    exp_match = 1'b0;
    exp_done  = 1'b0;
    if (owner >= 0) begin
      if (req[owner]) begin
        q.push_back(in[owner]);
        if (q.size() >= PLEN) begin
          v = 0;
          for (int j = q.size() - PLEN; j < q.size(); j++) v = v * 2 + int'(q[j]);
          if (v == int'(PATTERN)) begin
            exp_match = 1'b1;
            exp_mid   = owner;
          end
        end
        if (q.size() == BURST) begin
          owner = -1; cooldown = 1; exp_done = 1'b1;
        end
      end else begin
        owner = -1; cooldown = 1; exp_done = 1'b1;
      end
    end else if (cooldown > 0) begin
      cooldown--;
    end else if (req != '0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (owner < 0 && req[c]) owner = c;
      end
      m_last = owner;
      q.delete();
    end
    exp_gnt  = (owner >= 0) ? N'(1 << owner) : '0;
    exp_busy = (owner >= 0) || (cooldown > 0);
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (gnt === exp_gnt) else begin
      bad++; $error("[TB] FAIL %s gnt got=%b want=%b", tag, gnt, exp_gnt);
    end
    total++;
    assert (busy === exp_busy) else begin
      bad++; $error("[TB] FAIL %s busy got=%b want=%b", tag, busy, exp_busy);
    end
    total++;
    assert (match === exp_match) else begin
      bad++; $error("[TB] FAIL %s match got=%b want=%b", tag, match, exp_match);
    end
    total++;
    assert (done === exp_done) else begin
      bad++; $error("[TB] FAIL %s done got=%b want=%b", tag, done, exp_done);
    end
    if (exp_match) begin
      total++;
      assert (match_id === IW'(exp_mid)) else begin
        bad++; $error("[TB] FAIL %s match_id got=%0d want=%0d", tag, match_id, exp_mid);
      end
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] d, input string tag);
    @(negedge clk);
    req = r;
    in  = d;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
    if (match === 1'b1) matchSeen++;
    if (gnt !== '0 && prevGnt === '0) begin
      for (int i = 0; i < N; i++) if (gnt[i]) grantLog.push_back(i);
    end
    prevGnt = gnt;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; req = '0; in = '0;
    #1;
    modelReset();
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b0;
    prevGnt = '0;
  endtask

  task automatic checkCount(input string tag, input int got, input int want);
    total++;
    assert (got == want) else begin
      bad++; $error("[TB] FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  initial begin
    logic [7:0]   s2;
    logic [N-1:0] rq;
    total = 0; bad = 0; matchSeen = 0; prevGnt = '0;
    rst = 1'b0; req = '0; in = '0;
    modelReset();

    // reset pulse from 5ns to 7ns
    #5 rst = 1'b1;
    #1 checkOutput("reset_async");
    #1 rst = 1'b0;
    applyStimulus('0, '0, "idle_after_reset");

    // single lane, stream 1,1,0,1,1,0,0,0
    $display("[TB] single lane");
    s2 = 8'b1101_1000;
    matchSeen = 0;
    applyStimulus(4'b0001, '0, "single_grant");
    for (int i = 7; i >= 0; i--) applyStimulus(4'b0001, {3'b000, s2[i]}, "single_bits");
    applyStimulus('0, '0, "single_gap");
    applyStimulus('0, '0, "single_idle");
    checkCount("single_matches", matchSeen, 2);

    // round robin among lanes 0,1,3
    $display("[TB] round robin");
    doReset();
    matchSeen = 0;
    grantLog.delete();
    for (int i = 0; i < 40; i++) applyStimulus(4'b1011, '0, "rr");
    checkCount("rr_grants", grantLog.size(), 4);
    if (grantLog.size() == 4) begin
      checkCount("rr_g0", grantLog[0], 0);
      checkCount("rr_g1", grantLog[1], 1);
      checkCount("rr_g2", grantLog[2], 3);
      checkCount("rr_g3", grantLog[3], 0);
    end
    checkCount("rr_matches", matchSeen, 0);

    // early drop on lane 2, then a fresh grant starting with 0
    $display("[TB] early drop");
    doReset();
    matchSeen = 0;
    applyStimulus(4'b0100, '0, "drop_grant");
    applyStimulus(4'b0100, 4'b0100, "drop_b1");
    applyStimulus(4'b0100, 4'b0100, "drop_b2");
    applyStimulus('0, '0, "drop_release");
    applyStimulus('0, '0, "drop_idle");
    applyStimulus(4'b0100, '0, "regrant");
    applyStimulus(4'b0100, '0, "regrant_b1");
    applyStimulus(4'b0100, 4'b0100, "regrant_b2");
    applyStimulus('0, '0, "regrant_drop");
    applyStimulus('0, '0, "regrant_idle");
    checkCount("drop_matches", matchSeen, 0);

    // lane 0 sends all ones, lane 1 all zeros: no match may straddle the handover
    $display("[TB] isolation");
    doReset();
    matchSeen = 0;
    for (int i = 0; i < 22; i++) applyStimulus(4'b0011, 4'b0001, "iso");
    checkCount("iso_matches", matchSeen, 0);

    // reset in the middle of a grant to lane 2
    $display("[TB] mid-grant reset");
    doReset();
    applyStimulus(4'b0100, '0, "mid_grant");
    for (int i = 0; i < 4; i++) applyStimulus(4'b0100, 4'b0100, "mid_bits");
    #2 rst = 1'b1;
    #1 modelReset();
    checkOutput("mid_reset");
    @(negedge clk);
    rst = 1'b0; req = '0;
    prevGnt = '0;
    applyStimulus(4'b0101, '0, "after_reset_grant");
    total++;
    assert (gnt === 4'b0001) else begin
      bad++; $error("[TB] FAIL rr_after_reset gnt got=%b want=0001", gnt);
    end
    for (int i = 0; i < 12; i++) applyStimulus(4'b0101, 4'b0101, "after_reset");

    // random traffic with sticky requests
    $display("[TB] random");
    rq = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) rq[b] = ~rq[b];
      applyStimulus(rq, N'($urandom), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_detect_arbiter.md
Name: seq_detect_arbiter

Overview:
Round-robin arbiter and sequencer that shares one serial pattern-detector FSM among N serial bit sources. It grants one requester at a time for a bounded burst and clears the detector state at the start of every grant. It samples the granted lane's bit each cycle and reports pattern matches tagged with the owning requester. It sits in front of the detector datapath so several input streams can use one detector without cross-contamination of state.

Parameters:
N, 4, number of requesters (2..8)
PLEN, 3, pattern length in bits (2..8)
PATTERN, 3'b110, target pattern; oldest bit in MSB, newest bit in LSB
BURST, 8, maximum bits sampled per grant (>= PLEN, <= 255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req  input  N  per-requester request; held high while the lane has bits to send
in  input  N  per-requester serial bit; in[i] is valid while req[i] is high
gnt  output  N  one-hot grant, registered
busy  output  1  high in GRANT and GAP states
match  output  1  one-cycle pulse: pattern completed on the granted lane
match_id  output  $clog2(N)  requester index for the current match, valid while match is high
done  output  1  one-cycle pulse: grant ended (burst exhausted or request dropped)

Behaviour:
- Reset (async, rst=1): state=IDLE; gnt=0; busy=0; match=0; match_id=0; done=0; shift window=0; bit count=0; last-grant pointer=N-1, so requester 0 has first priority. Asserting rst mid-grant aborts immediately: gnt drops with no done pulse, and the partial window is discarded.
- FSM states: IDLE, GRANT, GAP.
- IDLE: on an edge where req != 0, pick the first set bit searching upward from last+1 modulo N. At that same edge: gnt <= onehot(winner), last <= winner, window <= 0, count <= 0, state <= GRANT. So gnt rises one cycle after req is first seen. If req == 0, stay in IDLE.
- GRANT, granted index g, at each edge:
  - If req[g] = 1: window <= {window[PLEN-2:0], in[g]}; count <= count+1.
  - If the new count == BURST: state <= GAP, gnt <= 0.
  - If req[g] = 0: sample nothing; state <= GAP, gnt <= 0.
  - Requests from other lanes are ignored during GRANT. No preemption.
- GAP: lasts exactly one cycle with gnt=0, then state <= IDLE. Arbitration happens in the IDLE cycle that follows, so there are at least 2 cycles between one lane's grant ending and the next gnt rising.
- match: registered. At a sampling edge, match <= (new count >= PLEN) && (new window == PATTERN), and match_id <= g at the same edge. Otherwise match <= 0.
  - The pulse appears in the cycle after the completing bit is sampled. This may fall in the GAP cycle when the last burst bit completes the pattern.
  - Overlapping matches are allowed.
  - Bits from a previous grant never contribute to a match.
- done: registered. It pulses high for exactly the GAP cycle.
- busy = (state != IDLE).
- A requester that drops req and re-raises it competes normally and receives a fresh, cleared window.

Test Plan:
1. Reset: rst high at t=5ns, released at 7ns, req=0 -> gnt=0, busy=0, match=0, done=0 from 5ns onward.
2. Single lane: req[0]=1, in[0] stream 1,1,0,1,1,0,0,0 -> gnt=4'b0001 for 8 sampling cycles; match pulses after bit 3 and after bit 6 with match_id=0; done pulses in the GAP cycle after bit 8; gnt=0 during GAP.
3. Round-robin: req=4'b1011 held high with in=0 -> grant order 0,1,3,0, each grant 8 bits, separated by a GAP cycle plus an IDLE cycle; no match.
4. Early drop: lane 2 granted, sends 1,1, then req[2]=0 -> no match; done pulses the following cycle. The next grant to lane 2 sends 0 as its first bit -> no match, which proves the window was cleared.
5. Cross-lane isolation: lane 0 ends its burst with bits ...1,1 and lane 1 starts with 0 -> no match on lane 1.
6. Reset mid-grant: assert rst after 4 bits of a grant -> gnt=0 asynchronously, no done pulse; after release, requester 0 wins first.
